// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage sitting directly upstream of decode/control.
// Owns the program counter, fetches one 32-bit instruction at a time over a
// request/response memory handshake and presents it to decode together with
// the op/funct3/funct7b5 slices the control unit consumes directly.
// PC redirects (taken branch/jump) override everything and any fetch that is
// still in flight at the time of a redirect is discarded.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a non word-aligned target raises fetch_fault
//               (sticky until reset) and parks the unit in a halt state.
//   undefined : fetch_fault is tied low and redirect_pc[1:0] are ignored.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   imem_req_*       fetch request: valid/ready handshake, word address
//   imem_rsp_*       fetch response: valid strobe and instruction word
//   instr_valid/ready, instr, instr_pc, instr_pc_plus4
//                    instruction handed to decode with its address
//   op, funct3, funct7b5
//                    instruction fields for the control unit
//   redirect_valid/pc
//                    load a new PC (branch taken or jump)
//   fetch_fault      misaligned redirect target seen (optional feature)
//
// Every output is either a register or decoded from state registers only, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus4,
   output logic [6:0]      op,
   output logic [2:0]      funct3,
   output logic            funct7b5,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_fault
);

`ifdef FETCH_MISALIGN_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP,
      S_HALT
   } state_t;

   state_t            state;
   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   redirect_tgt;
   logic              redirect_bad;

   // Redirect targets are always word aligned on the way into the PC; the two
   // low bits only matter for detecting a misaligned target when the check
   // is built in, otherwise the bad-redirect flag is constant low.
   assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
   assign redirect_bad = CHK_EN && redirect_valid && (redirect_pc[1:0] != 2'b00);

   // Outputs decoded from state: a request is presented only in REQ and an
   // instruction is offered to decode only in HOLD. The request address is
   // simply the PC, which holds still in REQ until accepted or redirected.
   assign imem_req_valid = (state == S_REQ);
   assign imem_req_addr  = pc;
   assign instr_valid    = (state == S_HOLD);
   assign instr_pc_plus4 = instr_pc + PC_STEP;
   assign op             = instr[6:0];
   assign funct3         = instr[14:12];
   assign funct7b5       = instr[30];

   // Main fetch sequencer. Only one request is ever outstanding. A redirect
   // always wins: it reloads the PC and, depending on whether a request is
   // already in flight, either goes straight back to REQ or passes through
   // DROP to swallow the one stale response still owed by memory.
   // In DROP a redirect that lands together with the awaited response also
   // leaves for REQ, since that response is the one being swallowed and
   // waiting for another would stall forever.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         instr    <= '0;
         instr_pc <= '0;
      end else if (redirect_bad) begin
         state <= S_HALT;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_REQ;
               if (redirect_valid) pc <= redirect_tgt;
            end
            S_REQ: begin
               if (redirect_valid) begin
                  pc    <= redirect_tgt;
                  state <= imem_req_ready ? S_DROP : S_REQ;
               end else if (imem_req_ready) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  pc    <= redirect_tgt;
                  state <= imem_rsp_valid ? S_REQ : S_DROP;
               end else if (imem_rsp_valid) begin
                  instr    <= imem_rsp_data;
                  instr_pc <= pc;
                  pc       <= pc + PC_STEP;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  pc    <= redirect_tgt;
                  state <= S_REQ;
               end else if (instr_ready) begin
                  state <= S_REQ;
               end
            end
            S_DROP: begin
               if (redirect_valid) pc <= redirect_tgt;
               if (imem_rsp_valid) state <= S_REQ;
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   logic fault_q;

   // Sticky misaligned-target flag; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (redirect_bad) begin
         fault_q <= 1'b1;
      end
   end

   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A small instruction memory model lives
// in the step task: it accepts requests, answers after mem_lat cycles with a
// word derived from the address and pushes the expected {pc, instr} pair on
// a scoreboard queue unless the scenario says that response must be dropped.
// Each scenario task pops the scoreboard when decode sees an instruction and
// also checks the address it independently expects.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_fault;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          mem_lat;
   int          pend_cnt;
   int          drop_cnt;
   bit          pend;
   logic [31:0] pend_addr;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4),
      .op             (op),
      .funct3         (funct3),
      .funct7b5       (funct7b5),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, required the test sequence to finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_4033;
   endfunction

   // One clock: record any handshake seen before the edge, then after the
   // edge advance the memory model and drive its response for the new cycle.
   task automatic step();
      logic        acc;
      logic [31:0] a;
      logic [31:0] d;
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (acc) begin
         pend      = 1'b1;
         pend_cnt  = mem_lat;
         pend_addr = a;
      end
      if (pend) begin
         if (pend_cnt <= 1) begin
            d              = mem_word(pend_addr);
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = d;
            pend           = 1'b0;
            if (drop_cnt > 0) drop_cnt--;
            else exp_q.push_back('{pc: pend_addr, data: d});
         end else begin
            pend_cnt--;
         end
      end
   endtask

   task automatic wait_instr(input int budget, output bit seen, output int n);
      n    = 0;
      seen = instr_valid;
      while (!seen && n < budget) begin
         step();
         n++;
         seen = instr_valid;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      vectors++;
      if ({imem_req_valid, instr_valid, fetch_fault, instr, instr_pc, imem_req_addr} !== {3'b000, 96'h0}) begin
         miscompares++;
         $display("[TB] FAIL reset_values: got req_valid=%b instr_valid=%b fault=%b instr=%h instr_pc=%h addr=%h, required all zero",
                  imem_req_valid, instr_valid, fetch_fault, instr, instr_pc, imem_req_addr);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_idle_cycle: got req_valid=%b, required 0", imem_req_valid);
      end
      step();
      vectors++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
         miscompares++;
         $display("[TB] FAIL reset_first_req: got valid=%b addr=%h, required valid=1 addr=00000000", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_basic();
      bit   seen;
      int   n;
      exp_t e;
      wait_instr(10, seen, n);
      vectors++;
      if (!seen || n != 2 || exp_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL basic_latency: got valid=%b after %0d cycles queued=%0d, required valid after 2 cycles with 1 queued",
                  seen, n, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({instr, instr_pc, instr_pc_plus4} !== {e.data, 32'h0, 32'h4}) begin
            miscompares++;
            $display("[TB] FAIL basic_instr: got instr=%h pc=%h pc4=%h, required instr=%h pc=00000000 pc4=00000004",
                     instr, instr_pc, instr_pc_plus4, e.data);
         end
         vectors++;
         if ({op, funct3, funct7b5} !== {7'h13, 3'h0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL basic_fields: got op=%h f3=%h f7b5=%b, required op=13 f3=0 f7b5=0", op, funct3, funct7b5);
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      vectors++;
      if ({instr_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h4}) begin
         miscompares++;
         $display("[TB] FAIL basic_next_req: got instr_valid=%b req_valid=%b addr=%h, required 0 1 00000004",
                  instr_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_hold_stall();
      bit   seen;
      int   n;
      exp_t e;
      wait_instr(10, seen, n);
      vectors++;
      if (!seen || exp_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL stall_timeout: got valid=%b queued=%0d, required valid=1 with 1 queued", seen, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({instr, instr_pc, instr_pc_plus4} !== {e.data, 32'h4, 32'h8}) begin
            miscompares++;
            $display("[TB] FAIL stall_instr: got instr=%h pc=%h pc4=%h, required instr=%h pc=00000004 pc4=00000008",
                     instr, instr_pc, instr_pc_plus4, e.data);
         end
         vectors++;
         if ({op, funct3, funct7b5} !== {e.data[6:0], e.data[14:12], e.data[30]}) begin
            miscompares++;
            $display("[TB] FAIL stall_fields: got op=%h f3=%h f7b5=%b, required op=%h f3=%h f7b5=%b",
                     op, funct3, funct7b5, e.data[6:0], e.data[14:12], e.data[30]);
         end
         for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({instr_valid, imem_req_valid, instr, instr_pc} !== {2'b10, e.data, 32'h4}) begin
               miscompares++;
               $display("[TB] FAIL stall_cycle%0d: got valid=%b req=%b instr=%h pc=%h, required 1 0 %h 00000004",
                        i, instr_valid, imem_req_valid, instr, instr_pc, e.data);
            end
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_wait();
      bit   seen;
      int   n;
      exp_t e;
      mem_lat = 3;
      step();
      drop_cnt       = 1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (instr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rdw_no_instr%0d: got instr_valid=%b, required 0", i, instr_valid);
         end
         step();
      end
      vectors++;
      if ({instr_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h40}) begin
         miscompares++;
         $display("[TB] FAIL rdw_req: got instr_valid=%b req_valid=%b addr=%h, required 0 1 00000040",
                  instr_valid, imem_req_valid, imem_req_addr);
      end
      mem_lat = 1;
      wait_instr(10, seen, n);
      vectors++;
      if (!seen || exp_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL rdw_timeout: got valid=%b queued=%0d, required valid=1 with 1 queued", seen, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({instr, instr_pc} !== {e.data, 32'h40}) begin
            miscompares++;
            $display("[TB] FAIL rdw_instr: got instr=%h pc=%h, required instr=%h pc=00000040", instr, instr_pc, e.data);
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_rsp();
      bit   seen;
      int   n;
      exp_t e;
      drop_cnt = 1;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      step();
      redirect_valid = 1'b0;
      vectors++;
      if ({instr_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h80}) begin
         miscompares++;
         $display("[TB] FAIL rdr_req: got instr_valid=%b req_valid=%b addr=%h, required 0 1 00000080",
                  instr_valid, imem_req_valid, imem_req_addr);
      end
      wait_instr(10, seen, n);
      vectors++;
      if (!seen || exp_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL rdr_timeout: got valid=%b queued=%0d, required valid=1 with 1 queued", seen, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({instr, instr_pc, instr_pc_plus4} !== {e.data, 32'h80, 32'h84}) begin
            miscompares++;
            $display("[TB] FAIL rdr_instr: got instr=%h pc=%h pc4=%h, required instr=%h pc=00000080 pc4=00000084",
                     instr, instr_pc, instr_pc_plus4, e.data);
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
   endtask

   task automatic test_redirect_hold();
      bit   seen;
      int   n;
      exp_t e;
      wait_instr(10, seen, n);
      vectors++;
      if (!seen || exp_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL rdh_timeout: got valid=%b queued=%0d, required valid=1 with 1 queued", seen, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({instr, instr_pc} !== {e.data, 32'h84}) begin
            miscompares++;
            $display("[TB] FAIL rdh_instr: got instr=%h pc=%h, required instr=%h pc=00000084", instr, instr_pc, e.data);
         end
      end
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      step();
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      vectors++;
      if ({instr_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h200}) begin
         miscompares++;
         $display("[TB] FAIL rdh_req: got instr_valid=%b req_valid=%b addr=%h, required 0 1 00000200",
                  instr_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_pc_wrap();
      bit   seen;
      int   n;
      exp_t e;
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      vectors++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         miscompares++;
         $display("[TB] FAIL wrap_req_change: got valid=%b addr=%h, required valid=1 addr=fffffffc", imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      wait_instr(10, seen, n);
      vectors++;
      if (!seen || exp_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL wrap_timeout: got valid=%b queued=%0d, required valid=1 with 1 queued", seen, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({instr, instr_pc, instr_pc_plus4} !== {e.data, 32'hFFFF_FFFC, 32'h0}) begin
            miscompares++;
            $display("[TB] FAIL wrap_instr: got instr=%h pc=%h pc4=%h, required instr=%h pc=fffffffc pc4=00000000",
                     instr, instr_pc, instr_pc_plus4, e.data);
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      vectors++;
      if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
         miscompares++;
         $display("[TB] FAIL wrap_next_req: got valid=%b addr=%h, required valid=1 addr=00000000", imem_req_valid, imem_req_addr);
      end
   endtask

   task automatic test_misalign();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h102;
      step();
      redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      vectors++;
      if ({fetch_fault, imem_req_valid, instr_valid} !== 3'b100) begin
         miscompares++;
         $display("[TB] FAIL misalign_fault: got fault=%b req_valid=%b instr_valid=%b, required 1 0 0",
                  fetch_fault, imem_req_valid, instr_valid);
      end
      imem_req_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         vectors++;
         if ({fetch_fault, imem_req_valid, instr_valid} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL misalign_halt%0d: got fault=%b req_valid=%b instr_valid=%b, required 1 0 0",
                     i, fetch_fault, imem_req_valid, instr_valid);
         end
      end
`else
      vectors++;
      if ({fetch_fault, imem_req_valid, imem_req_addr} !== {2'b01, 32'h100}) begin
         miscompares++;
         $display("[TB] FAIL misalign_ignored: got fault=%b req_valid=%b addr=%h, required 0 1 00000100",
                  fetch_fault, imem_req_valid, imem_req_addr);
      end
`endif
   endtask

   task automatic test_reset_mid();
      bit   seen;
      int   n;
      exp_t e;
      imem_req_ready = 1'b1;
      mem_lat        = 3;
      step();
      drop_cnt = pend ? 1 : 0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({imem_req_valid, instr_valid, fetch_fault, instr, instr_pc, imem_req_addr} !== {3'b000, 96'h0}) begin
         miscompares++;
         $display("[TB] FAIL mid_reset_values: got req_valid=%b instr_valid=%b fault=%b instr=%h pc=%h addr=%h, required all zero",
                  imem_req_valid, instr_valid, fetch_fault, instr, instr_pc, imem_req_addr);
      end
      imem_req_ready = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      vectors++;
      if ({instr_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h0}) begin
         miscompares++;
         $display("[TB] FAIL mid_stale_rsp: got instr_valid=%b req_valid=%b addr=%h, required 0 1 00000000",
                  instr_valid, imem_req_valid, imem_req_addr);
      end
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      wait_instr(10, seen, n);
      vectors++;
      if (!seen || exp_q.size() == 0) begin
         miscompares++;
         $display("[TB] FAIL mid_timeout: got valid=%b queued=%0d, required valid=1 with 1 queued", seen, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if ({instr, instr_pc} !== {32'h0050_0093, 32'h0} || e.data !== 32'h0050_0093) begin
            miscompares++;
            $display("[TB] FAIL mid_refetch: got instr=%h pc=%h, required instr=00500093 pc=00000000", instr, instr_pc);
         end
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
   endtask

   task automatic test_scoreboard_drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d undelivered responses, required 0", exp_q.size());
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      mem_lat        = 1;
      pend           = 1'b0;
      pend_cnt       = 0;
      pend_addr      = 32'h0;
      drop_cnt       = 0;
      $display("[TB] starting fetch_unit bench");
      test_reset();
      test_basic();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_rsp();
      test_redirect_hold();
      test_pc_wrap();
      test_misalign();
      test_reset_mid();
      test_scoreboard_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
